// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - gshare direction predictor: 2-bit counters indexed by PC xor global history,
// trained at EX resolve, with mispredict flag and branch statistics.

module branch_predictor #(
    parameter int IDX_BITS = 6,
    parameter int GHR_BITS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                pred_valid,
    input  logic [31:0]         pred_pc,
    output logic                pred_taken,
    output logic [IDX_BITS-1:0] pred_idx,
    input  logic                resolve_valid,
    input  logic [IDX_BITS-1:0] resolve_idx,
    input  logic                resolve_br_en,
    input  logic                resolve_pred,
    output logic                mispredict,
    output logic [31:0]         branch_cnt,
    output logic [31:0]         mispred_cnt
);

    localparam int ENTRIES = 1 << IDX_BITS;

    logic [1:0]          ctr [ENTRIES];
    logic [1:0]          ctr_cur;
    logic [1:0]          ctr_upd;
    logic [GHR_BITS-1:0] ghr;
    logic [GHR_BITS-1:0] ghr_next;
    logic [IDX_BITS-1:0] ghr_ext;
    logic                unused_pred;

    // Prediction outputs are driven from pred_pc regardless of pred_valid.
    assign unused_pred = ^{pred_valid, pred_pc[31:IDX_BITS+2], pred_pc[1:0]};

    assign ghr_ext    = IDX_BITS'(ghr);
    assign pred_idx   = pred_pc[IDX_BITS+1:2] ^ ghr_ext;
    assign pred_taken = ctr[pred_idx][1];

    // Gated by rst_n so no flush is requested while the predictor is held in reset.
    assign mispredict = rst_n & resolve_valid & (resolve_br_en != resolve_pred);

    generate
        if (GHR_BITS == 1) begin : g_ghr_one
            assign ghr_next = resolve_br_en;
        end else begin : g_ghr_shift
            assign ghr_next = {ghr[GHR_BITS-2:0], resolve_br_en};
        end
    endgenerate

    always_comb begin
        ctr_cur = ctr[resolve_idx];
        ctr_upd = ctr_cur;
        if (resolve_br_en) begin
            if (ctr_cur != 2'b11) ctr_upd = ctr_cur + 2'b01;
        end else begin
            if (ctr_cur != 2'b00) ctr_upd = ctr_cur - 2'b01;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) ctr[i] <= 2'b01;
        end else if (resolve_valid) begin
            ctr[resolve_idx] <= ctr_upd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ghr         <= '0;
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else if (resolve_valid) begin
            ghr        <= ghr_next;
            branch_cnt <= branch_cnt + 32'd1;
            if (mispredict) mispred_cnt <= mispred_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - directed self-checking bench for branch_predictor (IDX_BITS=6, GHR_BITS=4).

module tb_branch_predictor;

    logic        clk;
    logic        rst_n;
    logic        pred_valid;
    logic [31:0] pred_pc;
    logic        pred_taken;
    logic [5:0]  pred_idx;
    logic        resolve_valid;
    logic [5:0]  resolve_idx;
    logic        resolve_br_en;
    logic        resolve_pred;
    logic        mispredict;
    logic [31:0] branch_cnt;
    logic [31:0] mispred_cnt;

    int n_checks;
    int n_fail;

    branch_predictor #(.IDX_BITS(6), .GHR_BITS(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pred_valid   (pred_valid),
        .pred_pc      (pred_pc),
        .pred_taken   (pred_taken),
        .pred_idx     (pred_idx),
        .resolve_valid(resolve_valid),
        .resolve_idx  (resolve_idx),
        .resolve_br_en(resolve_br_en),
        .resolve_pred (resolve_pred),
        .mispredict   (mispredict),
        .branch_cnt   (branch_cnt),
        .mispred_cnt  (mispred_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic resolve(input logic [5:0] idx, input logic br_en, input logic pred);
        resolve_valid = 1'b1;
        resolve_idx   = idx;
        resolve_br_en = br_en;
        resolve_pred  = pred;
        tick();
        resolve_valid = 1'b0;
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        rst_n         = 1'b0;
        pred_valid    = 1'b1;
        pred_pc       = 32'h0;
        resolve_valid = 1'b0;
        resolve_idx   = 6'd0;
        resolve_br_en = 1'b0;
        resolve_pred  = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // 1: reset state, every PC predicts not-taken
        for (int pc = 0; pc <= 32'hFC; pc += 4) begin
            pred_pc = pc;
            #1;
            check_eq("sweep_pred_taken", {31'b0, pred_taken}, 32'd0);
        end
        check_eq("reset_branch_cnt", branch_cnt, 32'd0);
        check_eq("reset_mispred_cnt", mispred_cnt, 32'd0);
        check_eq("reset_ghr", {28'b0, dut.ghr}, 32'd0);

        // 2: first mispredict at idx 16 (pc 0x40, ghr 0)
        pred_pc = 32'h40;
        #1;
        check_eq("idx_pc40", {26'b0, pred_idx}, 32'd16);
        resolve_valid = 1'b1;
        resolve_idx   = 6'd16;
        resolve_br_en = 1'b1;
        resolve_pred  = 1'b0;
        #1;
        check_eq("mispredict_comb", {31'b0, mispredict}, 32'd1);
        tick();
        resolve_valid = 1'b0;
        #1;
        check_eq("mispredict_idle", {31'b0, mispredict}, 32'd0);
        check_eq("ctr16_after_t", {30'b0, dut.ctr[16]}, 32'd2);
        check_eq("mispred_cnt_1", mispred_cnt, 32'd1);
        check_eq("branch_cnt_1", branch_cnt, 32'd1);
        check_eq("ghr_0001", {28'b0, dut.ghr}, 32'd1);
        check_eq("idx_pc40_ghr1", {26'b0, pred_idx}, 32'd17);
        pred_pc = 32'h44;
        #1;
        check_eq("pred_taken_ctr16", {31'b0, pred_taken}, 32'd1);

        // 3: saturate high, then one not-taken
        for (int k = 0; k < 5; k++) resolve(6'd16, 1'b1, 1'b1);
        #1;
        check_eq("ctr16_sat_hi", {30'b0, dut.ctr[16]}, 32'd3);
        check_eq("ghr_after_taken", {28'b0, dut.ghr}, 32'hF);
        check_eq("branch_cnt_6", branch_cnt, 32'd6);
        check_eq("mispred_cnt_still1", mispred_cnt, 32'd1);
        resolve(6'd16, 1'b0, 1'b1);
        #1;
        check_eq("ctr16_dec", {30'b0, dut.ctr[16]}, 32'd2);
        check_eq("ghr_1110", {28'b0, dut.ghr}, 32'hE);
        check_eq("mispred_cnt_2", mispred_cnt, 32'd2);
        pred_pc = 32'h78;
        #1;
        check_eq("idx_pc78", {26'b0, pred_idx}, 32'd16);
        check_eq("pred_taken_weak", {31'b0, pred_taken}, 32'd1);

        // 4: same-cycle predict and train at idx 16
        resolve_valid = 1'b1;
        resolve_idx   = 6'd16;
        resolve_br_en = 1'b0;
        resolve_pred  = 1'b1;
        #1;
        check_eq("same_cyc_pred_old", {31'b0, pred_taken}, 32'd1);
        check_eq("same_cyc_idx_old", {26'b0, pred_idx}, 32'd16);
        check_eq("same_cyc_mispredict", {31'b0, mispredict}, 32'd1);
        tick();
        resolve_valid = 1'b0;
        #1;
        check_eq("same_cyc_idx_new", {26'b0, pred_idx}, 32'd18);
        pred_pc = 32'h70;
        #1;
        check_eq("same_cyc_pred_new", {31'b0, pred_taken}, 32'd0);
        check_eq("branch_cnt_8", branch_cnt, 32'd8);
        check_eq("mispred_cnt_3", mispred_cnt, 32'd3);
        resolve_br_en = 1'b1;
        resolve_pred  = 1'b0;
        #1;
        check_eq("no_valid_no_mispredict", {31'b0, mispredict}, 32'd0);

        // saturate low at idx 5
        resolve(6'd5, 1'b0, 1'b0);
        resolve(6'd5, 1'b0, 1'b0);
        #1;
        check_eq("ctr5_sat_lo", {30'b0, dut.ctr[5]}, 32'd0);
        check_eq("ghr_0000", {28'b0, dut.ghr}, 32'd0);
        check_eq("branch_cnt_10", branch_cnt, 32'd10);

        // 5: async reset between edges, mid-training
        resolve(6'd16, 1'b1, 1'b0);
        resolve(6'd16, 1'b1, 1'b1);
        #1;
        check_eq("ctr16_pre_rst", {30'b0, dut.ctr[16]}, 32'd3);
        resolve_valid = 1'b1;
        resolve_idx   = 6'd16;
        resolve_br_en = 1'b1;
        resolve_pred  = 1'b0;
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("arst_branch_cnt", branch_cnt, 32'd0);
        check_eq("arst_mispred_cnt", mispred_cnt, 32'd0);
        check_eq("arst_ghr", {28'b0, dut.ghr}, 32'd0);
        check_eq("arst_ctr16", {30'b0, dut.ctr[16]}, 32'd1);
        check_eq("arst_mispredict", {31'b0, mispredict}, 32'd0);
        pred_pc = 32'h40;
        #1;
        check_eq("arst_pred_taken", {31'b0, pred_taken}, 32'd0);
        tick();
        check_eq("rst_held_branch_cnt", branch_cnt, 32'd0);
        check_eq("rst_held_ctr16", {30'b0, dut.ctr[16]}, 32'd1);
        resolve_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // 6: branch_cnt wrap, correct prediction leaves mispred_cnt alone
        @(negedge clk);
        force dut.branch_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.branch_cnt;
        resolve(6'd3, 1'b0, 1'b0);
        #1;
        check_eq("branch_cnt_wrap", branch_cnt, 32'd0);
        check_eq("mispred_cnt_unchanged", mispred_cnt, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
